// File: rtl/prio_arbiter_n.sv
// N-input arbiter with a registered valid/ready grant (binary index and one-hot).
// Fixed-priority (highest index wins) or round-robin (descending from pointer) per arbitration.
module prio_arbiter_n #(
    parameter int N       = 8,
    parameter int RST_PTR = N - 1,
    localparam int W      = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_oh,
    output logic         grant_valid,
    input  logic         grant_ready,
    output logic [W-1:0] ptr_dbg
);
    localparam int WP = W + 1;

    logic           valid_r;
    logic [W-1:0]   idx_r;
    logic [N-1:0]   oh_r;
    logic [W-1:0]   ptr_r;

    logic           accept_s;
    logic           free_s;
    logic           any_s;
    logic [W-1:0]   ptr_nxt_s;
    logic [W-1:0]   fixed_idx_s;
    logic [W-1:0]   rot_hi_s;
    logic [W-1:0]   rr_idx_s;
    logic [W-1:0]   win_idx_s;
    logic [N-1:0]   win_oh_s;
    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;
    logic [WP-1:0]  shamt_s;
    logic [WP-1:0]  rr_sum_s;

    function automatic logic [W-1:0] hi_idx(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            r = v[i] ? W'(i) : r;
        end
        return r;
    endfunction

    assign accept_s = valid_r & grant_ready;
    assign free_s   = ~valid_r | grant_ready;
    assign any_s    = |req;

    // Pointer moves to just below the accepted index, only on round-robin acceptance.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (accept_s && mode) begin
            ptr_nxt_s = (idx_r == {W{1'b0}}) ? W'(N - 1) : idx_r - W'(1);
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Winner selection; the round-robin search rotates req so req[ptr] lands on the top bit,
    // then reuses the highest-set-bit search and maps the position back.
    always_comb begin
        dbl_s       = {req, req};
        shamt_s     = {1'b0, ptr_nxt_s} + WP'(1);
        rot_s       = N'(dbl_s >> shamt_s);
        rot_hi_s    = hi_idx(rot_s);
        rr_sum_s    = {1'b0, rot_hi_s} + {1'b0, ptr_nxt_s} + WP'(1);
        rr_idx_s    = (rr_sum_s >= WP'(N)) ? W'(rr_sum_s - WP'(N)) : W'(rr_sum_s);
        fixed_idx_s = hi_idx(req);
        win_idx_s   = mode ? rr_idx_s : fixed_idx_s;
        win_oh_s    = N'(1) << win_idx_s;
    end

    // Grant and pointer registers; a held grant is frozen until the slot frees up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            idx_r   <= {W{1'b0}};
            oh_r    <= {N{1'b0}};
            ptr_r   <= W'(RST_PTR);
        end else begin
            ptr_r <= ptr_nxt_s;
            if (free_s) begin
                valid_r <= any_s;
                idx_r   <= any_s ? win_idx_s : {W{1'b0}};
                oh_r    <= any_s ? win_oh_s : {N{1'b0}};
            end
        end
    end

    assign grant_valid = valid_r;
    assign grant_idx   = idx_r;
    assign grant_oh    = oh_r;
    assign ptr_dbg     = ptr_r;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Self-checking bench: directed N=4 vector table plus hand sequences, and a
// reference-model sweep on N=2, 5 and 32 instances.
module tb_prio_arbiter_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // N=4 directed instance
    logic [3:0] req4   = 4'b0000;
    logic       mode4  = 1'b0;
    logic       ready4 = 1'b0;
    logic [1:0] idx4;
    logic [3:0] oh4;
    logic       valid4;
    logic [1:0] ptr4;

    prio_arbiter_n #(.N(4)) u_n4 (
        .clk(clk), .rst(rst), .req(req4), .mode(mode4),
        .grant_idx(idx4), .grant_oh(oh4), .grant_valid(valid4),
        .grant_ready(ready4), .ptr_dbg(ptr4)
    );

    // Sweep instances
    logic [1:0]  req2 = 2'b0;   logic mode2 = 1'b0;  logic ready2 = 1'b0;
    logic [4:0]  req5 = 5'b0;   logic mode5 = 1'b0;  logic ready5 = 1'b0;
    logic [31:0] req32 = 32'b0; logic mode32 = 1'b0; logic ready32 = 1'b0;
    logic [0:0]  idx2;  logic [1:0]  oh2;  logic valid2;  logic [0:0] ptr2;
    logic [2:0]  idx5;  logic [4:0]  oh5;  logic valid5;  logic [2:0] ptr5;
    logic [4:0]  idx32; logic [31:0] oh32; logic valid32; logic [4:0] ptr32;

    prio_arbiter_n #(.N(2)) u_n2 (
        .clk(clk), .rst(rst), .req(req2), .mode(mode2),
        .grant_idx(idx2), .grant_oh(oh2), .grant_valid(valid2),
        .grant_ready(ready2), .ptr_dbg(ptr2)
    );
    prio_arbiter_n #(.N(5)) u_n5 (
        .clk(clk), .rst(rst), .req(req5), .mode(mode5),
        .grant_idx(idx5), .grant_oh(oh5), .grant_valid(valid5),
        .grant_ready(ready5), .ptr_dbg(ptr5)
    );
    prio_arbiter_n #(.N(32)) u_n32 (
        .clk(clk), .rst(rst), .req(req32), .mode(mode32),
        .grant_idx(idx32), .grant_oh(oh32), .grant_valid(valid32),
        .grant_ready(ready32), .ptr_dbg(ptr32)
    );

    logic [31:0] s_idx [3];
    logic [31:0] s_oh  [3];
    logic [31:0] s_ptr [3];
    logic        s_vld [3];
    assign s_idx[0] = 32'(idx2);  assign s_oh[0] = 32'(oh2);  assign s_ptr[0] = 32'(ptr2);  assign s_vld[0] = valid2;
    assign s_idx[1] = 32'(idx5);  assign s_oh[1] = 32'(oh5);  assign s_ptr[1] = 32'(ptr5);  assign s_vld[1] = valid5;
    assign s_idx[2] = 32'(idx32); assign s_oh[2] = 32'(oh32); assign s_ptr[2] = 32'(ptr32); assign s_vld[2] = valid32;

    typedef struct {
        logic [3:0] req;
        logic       mode;
        logic       ready;
        logic       valid;
        logic [1:0] idx;
        logic [3:0] oh;
        logic [1:0] ptr;
    } vec_t;

    vec_t tbl [31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check4(input string tag, input logic v, input logic [1:0] i,
                          input logic [3:0] o, input logic [1:0] p);
        check({tag, " valid"}, 32'(valid4), 32'(v));
        check({tag, " idx"},   32'(idx4),   32'(i));
        check({tag, " oh"},    32'(oh4),    32'(o));
        check({tag, " ptr"},   32'(ptr4),   32'(p));
    endtask

    // Reference winner: fixed = highest set bit; rr = descending search from ptr with wrap
    function automatic int pick(input logic [31:0] r, input int n, input int ptr, input logic md);
        if (!md) begin
            for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < n; k++) begin
                int j;
                j = (ptr - k + n) % n;
                if (r[j]) return j;
            end
        end
        return 0;
    endfunction

    int          nn [3] = '{2, 5, 32};
    int          mv [3];
    int          mi [3];
    int          mp [3];
    logic [31:0] sr [3];
    logic        sm [3];
    logic        sy [3];

    initial begin
        //                req      md    rdy   valid idx   oh       ptr
        tbl[0]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd3};
        tbl[1]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd3};
        tbl[2]  = '{4'b0001, 1'b0, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd3};
        tbl[3]  = '{4'b0010, 1'b0, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd3};
        tbl[4]  = '{4'b0100, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 2'd3};
        tbl[5]  = '{4'b1000, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd3};
        tbl[6]  = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd3};
        tbl[7]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd3};
        tbl[8]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd3};
        tbl[9]  = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 2'd2};
        tbl[10] = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd1};
        tbl[11] = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd0};
        tbl[12] = '{4'b1111, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd3};
        tbl[13] = '{4'b0101, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 2'd2};
        tbl[14] = '{4'b0101, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd1};
        tbl[15] = '{4'b0101, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 2'd3};
        tbl[16] = '{4'b1000, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd1};
        tbl[17] = '{4'b0001, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd1};
        tbl[18] = '{4'b0001, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd1};
        tbl[19] = '{4'b0001, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd1};
        tbl[20] = '{4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 2'd2};
        tbl[21] = '{4'b1111, 1'b0, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd2};
        tbl[22] = '{4'b0011, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd2};
        tbl[23] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0};
        tbl[24] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd0};
        tbl[25] = '{4'b1000, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 2'd0};
        tbl[26] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b1000, 2'd0};
        tbl[27] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 2'd2};
        tbl[28] = '{4'b0100, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 2'd2};
        tbl[29] = '{4'b0010, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 2'd1};
        tbl[30] = '{4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 2'd1};

        // Reset state while rst is held
        #12;
        check4("reset", 1'b0, 2'd0, 4'b0000, 2'd3);
        rst = 1'b0;

        for (int i = 0; i < 31; i++) begin
            req4   = tbl[i].req;
            mode4  = tbl[i].mode;
            ready4 = tbl[i].ready;
            @(posedge clk);
            #1;
            check4($sformatf("row%0d", i), tbl[i].valid, tbl[i].idx, tbl[i].oh, tbl[i].ptr);
        end

        // Asynchronous reset between edges while holding a round-robin grant with ptr=1
        #3;
        rst = 1'b1;
        #1;
        check4("async_rst", 1'b0, 2'd0, 4'b0000, 2'd3);
        #2;
        req4   = 4'b0010;
        mode4  = 1'b1;
        ready4 = 1'b1;
        rst    = 1'b0;
        @(posedge clk);
        #1;
        check4("post_rst", 1'b1, 2'd1, 4'b0010, 2'd3);
        req4   = 4'b0000;
        ready4 = 1'b0;

        // Randomised sweep against the reference model
        for (int k = 0; k < 3; k++) begin
            mv[k] = 0;
            mi[k] = 0;
            mp[k] = nn[k] - 1;
            sm[k] = 1'b1;
        end
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                logic [31:0] r;
                r = $urandom;
                if ($urandom_range(0, 2) == 0) r = r & $urandom & $urandom;
                if ($urandom_range(0, 7) == 0) r = 32'd0;
                sr[k] = r & 32'((64'd1 << nn[k]) - 64'd1);
                sy[k] = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 9) == 0) sm[k] = ~sm[k];
            end
            req2 = sr[0][1:0];  mode2 = sm[0];  ready2 = sy[0];
            req5 = sr[1][4:0];  mode5 = sm[1];  ready5 = sy[1];
            req32 = sr[2];      mode32 = sm[2]; ready32 = sy[2];
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                bit acc;
                bit fr;
                logic [31:0] exp_oh;
                acc = (mv[k] != 0) && sy[k];
                fr  = (mv[k] == 0) || sy[k];
                if (acc && sm[k]) mp[k] = (mi[k] == 0) ? nn[k] - 1 : mi[k] - 1;
                if (fr) begin
                    if (sr[k] != 32'd0) begin
                        mv[k] = 1;
                        mi[k] = pick(sr[k], nn[k], mp[k], sm[k]);
                    end else begin
                        mv[k] = 0;
                        mi[k] = 0;
                    end
                end
                exp_oh = (mv[k] != 0) ? (32'd1 << mi[k]) : 32'd0;
                check($sformatf("n%0d c%0d valid", nn[k], c), 32'(s_vld[k]), 32'(mv[k]));
                check($sformatf("n%0d c%0d idx", nn[k], c), s_idx[k], 32'(mi[k]));
                check($sformatf("n%0d c%0d oh", nn[k], c), s_oh[k], exp_oh);
                check($sformatf("n%0d c%0d ptr", nn[k], c), s_ptr[k], 32'(mp[k]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
